// File: rtl/fetch_unit.sv
// fetch_unit -- MIPS instruction-fetch stage, directly upstream of the instruction ROM.
//
// Owns the PC and drives the ROM with it. The ROM returns the word one cycle after
// the address is presented, so every issued PC has one read in flight. A single skid
// entry catches a returning word when decode is stalling, so no word is ever lost.
// A redirect (taken branch/jump) flushes everything and restarts fetch at the target.
//
// Optional feature macro: FETCH_PERF_COUNTERS_EN
//   defined   -> fetch_count counts accepted instructions, stall_count counts
//                back-pressure cycles (both 32-bit, wrapping, cleared only by reset)
//   undefined -> both counter ports tie to zero and no counter flops exist
//
// Ports
//   clock, reset         clock; synchronous active-high reset
//   rom_addr             byte address to ROM (equals fetch PC, bits [1:0] always 00)
//   rom_data             ROM word for the address presented last cycle
//   inst_valid/ready     valid/ready handshake toward decode
//   inst_out, inst_pc    instruction word and its PC
//   redirect_valid/pc    branch/jump taken and its target (bits [1:0] ignored)
//   fetch_count          instructions delivered (optional)
//   stall_count          cycles with inst_valid && !inst_ready (optional)

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  // The ROM decodes rom_addr[ADDR_WIDTH+1:2]; that slice must exist in a 32-bit address.
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
    $error("fetch_unit: ADDR_WIDTH must be in 1..30");
  end

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic issue, accept, load_out;

  assign rom_addr   = fetch_pc_q;
  assign inst_valid = out_valid_q;
  assign inst_out   = out_data_q;
  assign inst_pc    = out_pc_q;

  always_comb begin
    // Stop issuing once a stalled output already has a read behind it: the word
    // coming back next cycle will take the skid slot, and nothing else may follow.
    issue    = !reset && !redirect_valid && !skid_valid_q &&
               !(out_valid_q && !inst_ready && req_valid_q);
    accept   = out_valid_q && inst_ready;
    load_out = !out_valid_q || accept;

    fetch_pc_d   = fetch_pc_q;
    req_valid_d  = issue;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_pc_d     = out_pc_q;

    if (issue) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // Output register: the older skid entry always drains before the ROM word.
    if (load_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (req_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = rom_data;
        out_pc_d    = req_pc_q;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A returning word the output register did not take is parked in the skid.
    if (req_valid_q && !(load_out && !skid_valid_q)) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rom_data;
      skid_pc_d    = req_pc_q;
    end

    // Redirect wins over everything; a same-cycle accept has already completed.
    if (redirect_valid) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      req_valid_d  = 1'b0;
      fetch_pc_d   = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= 32'h0;
      skid_pc_q    <= 32'h0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 32'h0;
      out_pc_q     <= 32'h0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, stall_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      if (accept)                     fetch_count_q <= fetch_count_q + 32'd1;
      if (out_valid_q && !inst_ready) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural 1-cycle ROM, scoreboard of expected PCs that is
// refilled whenever reset or a redirect is driven, plus explicit latency/stall checks.

module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  fetch_unit #(.RESET_PC(RST_PC), .ADDR_WIDTH(12)) dut (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM word for byte address a: word index i holds 0x1000_0000 + i.
  function automatic logic [31:0] romf(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clock) rom_data <= romf(rom_addr);

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int since_rst = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start);
    logic [31:0] pc;
    exp_q.delete();
    pc = start;
    for (int i = 0; i < 48; i++) begin
      exp_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  // One cycle: drive inputs at negedge, then score any handshake completing at the
  // next posedge. Reset or redirect flushes the scoreboard to the new stream.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rst);
    logic [31:0] e;
    @(negedge clock);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset          = rst;
    #1;
    if (!rst && rdy && inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", inst_pc, e);
        chk("sb_data", inst_out, romf(e));
        delivered++;
        since_rst++;
      end
    end
    if (rv)  push_stream(rpc & 32'hFFFF_FFFC);
    if (rst) begin
      push_stream(RST_PC);
      since_rst = 0;
    end
  endtask

  task automatic run(input logic rdy);
    step(rdy, 1'b0, 32'h0, 1'b0);
  endtask

  int d0;

  initial begin
    reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rom_data = 32'h0;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", rom_addr, RST_PC);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_out", inst_out, 32'h0);
    chk("rst_fcnt", fetch_count, 32'h0);
    chk("rst_scnt", stall_count, 32'h0);

    // 1. Sequential fetch: first valid two cycles after reset drops
    run(1'b1); chk("seq_r0_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("seq_r1_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("seq_r2_valid", 32'(inst_valid), 32'd1);
    chk("seq_first_pc", inst_pc, 32'h0);
    chk("seq_first_data", inst_out, 32'h1000_0000);
    for (int i = 0; i < 3; i++) begin
      run(1'b1); chk("seq_thru_valid", 32'(inst_valid), 32'd1);
    end

    // 2. Stall with PC 0x10 presented
    for (int i = 0; i < 5; i++) begin
      run(1'b0);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_pc", inst_pc, 32'h10);
      chk("stall_data", inst_out, romf(32'h10));
    end
    d0 = delivered;
    run(1'b1);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("stall_scnt", stall_count, 32'd5);
    chk("stall_fcnt", fetch_count, 32'd4);
`else
    chk("stall_scnt", stall_count, 32'd0);
    chk("stall_fcnt", fetch_count, 32'd0);
`endif
    for (int i = 0; i < 3; i++) run(1'b1);
    chk("release_cnt", 32'(delivered - d0), 32'd3);
    run(1'b1); run(1'b1);

    // 3. Redirect to 0x203 -> 0x200 delivered at N+3
    step(1'b1, 1'b1, 32'h0000_0203, 1'b0);
    run(1'b1); chk("redir_n1_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("redir_n2_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("redir_n3_valid", 32'(inst_valid), 32'd1);
    chk("redir_n3_pc", inst_pc, 32'h200);
    run(1'b1); chk("redir_n4_pc", inst_pc, 32'h204);

    // 4. Redirect while stalled with out + skid full
    run(1'b0); run(1'b0);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    run(1'b1); chk("rds_n1_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("rds_n2_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("rds_n3_valid", 32'(inst_valid), 32'd1);
    chk("rds_n3_pc", inst_pc, 32'h40);
    run(1'b1);

    // Back-to-back redirects: the last target wins
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0300, 1'b0);
    run(1'b1); chk("b2b_n1_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("b2b_n2_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("b2b_n3_pc", inst_pc, 32'h300);
    run(1'b1); run(1'b1);

    // 5. Reset while skid is full
    run(1'b0); run(1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    run(1'b1);
    chk("mrst_valid", 32'(inst_valid), 32'd0);
    chk("mrst_addr", rom_addr, RST_PC);
    chk("mrst_fcnt", fetch_count, 32'h0);
    chk("mrst_scnt", stall_count, 32'h0);
    run(1'b1); chk("mrst_r1_valid", 32'(inst_valid), 32'd0);
    run(1'b1); chk("mrst_r2_pc", inst_pc, RST_PC);
    chk("mrst_r2_valid", 32'(inst_valid), 32'd1);
    run(1'b1);

    // 6. PC wrap
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
    run(1'b1); run(1'b1);
    run(1'b1); chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
    run(1'b1); chk("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    run(1'b1); chk("wrap_pc2", inst_pc, 32'h0000_0000);
    chk("wrap_data2", inst_out, 32'h1000_0000);
    run(1'b1);

    // Counter consistency against the bench's own delivery count since reset
    @(negedge clock);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("final_fcnt", fetch_count, 32'(since_rst));
`else
    chk("final_fcnt", fetch_count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
